// File: rtl/piradip_axis_sample_capture_if.sv
// AXI-stream handshake bundle for the sample capture stage.
// The master drives data and valid; the slave returns ready.
interface piradip_axis_sample_capture_if #(
  parameter int DATA_WIDTH = 256
);
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/piradip_axis_sample_capture.sv
// Captures a wide AXI stream into an internal beat memory, one-shot or ring mode,
// with a 32-bit registered readback port usable in any state.
//
// state      | meaning
// ST_IDLE    | stream not accepted, waiting for an enable write
// ST_CAPTURE | accepting one beat per cycle into mem[wptr]
// ST_DONE    | one-shot fill complete, stream blocked until the next control write
module piradip_axis_sample_capture #(
  parameter int STREAM_WIDTH      = 256,
  parameter int MEMORY_ADDR_WIDTH = 10,
  localparam int DEPTH = ((2 ** MEMORY_ADDR_WIDTH) * 8) / STREAM_WIDTH,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  piradip_axis_sample_capture_if.slave s,
  input  logic                         ctrl_wr,
  input  logic [1:0]                   ctrl_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         wrapped,
  output logic [CNT_W-1:0]             beat_count,
  input  logic                         rd_en,
  input  logic [MEMORY_ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]                  rd_data,
  output logic                         rd_valid
);

  localparam int LANES  = STREAM_WIDTH / 32;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int WORD_W = MEMORY_ADDR_WIDTH - 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [STREAM_WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wptr;
  logic             one_shot;
  logic             accept;
  logic             start;
  logic             last_slot;

  assign accept    = s.tvalid && s.tready;
  assign start     = ctrl_wr && ctrl_wdata[0];
  assign last_slot = (wptr == PTR_W'(DEPTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // A control write always takes priority over the end-of-fill transition.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        if (ctrl_wr) begin
          state_next = ctrl_wdata[0] ? ST_CAPTURE : ST_IDLE;
        end else if (accept && last_slot && one_shot) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (ctrl_wr) begin
          state_next = ctrl_wdata[0] ? ST_CAPTURE : ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    s.tready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      ST_CAPTURE: begin
        s.tready = 1'b1;
        busy     = 1'b1;
      end
      ST_DONE: begin
        done = 1'b1;
      end
      default: begin
        s.tready = 1'b0;
      end
    endcase
  end

  // A beat landing in the same cycle as a restart is stored but not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr       <= '0;
      beat_count <= '0;
      wrapped    <= 1'b0;
      one_shot   <= 1'b0;
    end else if (start) begin
      wptr       <= '0;
      beat_count <= '0;
      wrapped    <= 1'b0;
      one_shot   <= ctrl_wdata[1];
    end else if (accept) begin
      wptr <= last_slot ? '0 : wptr + 1'b1;
      if (beat_count != CNT_W'(DEPTH)) begin
        beat_count <= beat_count + 1'b1;
      end
      if (last_slot && !one_shot) begin
        wrapped <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wptr] <= s.tdata;
    end
  end

  logic [WORD_W-1:0]       rd_word;
  logic [PTR_W-1:0]        rd_beat;
  logic [LANE_W-1:0]       rd_lane;
  logic [STREAM_WIDTH-1:0] rd_beat_data;
  logic [31:0]             rd_lanes [LANES];
  logic                    unused_rd_addr_lsbs;

  assign rd_word             = rd_addr[MEMORY_ADDR_WIDTH-1:2];
  assign unused_rd_addr_lsbs = ^rd_addr[1:0];
  assign rd_beat             = PTR_W'(rd_word / LANES);
  assign rd_lane             = LANE_W'(rd_word % LANES);
  assign rd_beat_data        = mem[rd_beat];

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      rd_lanes[i] = rd_beat_data[32*i +: 32];
    end
  end

  // Sampling mem here alongside the write block gives read-first on a collision.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        rd_data <= rd_lanes[rd_lane];
      end
    end
  end

endmodule
